ps2_key_decoder: RTL and testbench



---
 rtl/ps2_key_decoder_if.sv | 29 ++
 rtl/ps2_key_decoder.sv | 189 ++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: scan-code input, ASCII FIFO handshake and key status bundle.
// slave is the decoder side, master is the producer/consumer side.
interface ps2_key_decoder_if #(
    parameter int unsigned COUNT_W = 8
);
    logic [7:0]         code_in;
    logic               code_valid;
    logic [7:0]         out_data;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         cur_ascii;
    logic               key_held;
    logic [COUNT_W-1:0] press_count;
    logic               shift_on;
    logic               caps_on;
    logic               overflow;

    modport master (
        output code_in, code_valid, out_ready,
        input  out_data, out_valid, cur_ascii, key_held, press_count, shift_on, caps_on,
               overflow
    );

    modport slave (
        input  code_in, code_valid, out_ready,
        output out_data, out_valid, cur_ascii, key_held, press_count, shift_on, caps_on,
               overflow
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 scan-code parser with Shift/Caps tracking, ASCII translation,
// fresh-press counter and a first-word-fall-through output FIFO.
// Optional feature: define PS2DEC_CAPSLOCK_EN to make code 0x58 toggle Caps Lock.
module ps2_key_decoder #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned COUNT_W = 8
) (
    input logic              clk,
    input logic              rst,
    ps2_key_decoder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_e;

    state_e             r_state, w_state_next;
    logic               w_make, w_break;
    logic               r_lshift, r_rshift, w_shift, w_caps;
    logic               r_key_held;
    logic [7:0]         r_held_code, r_cur_ascii;
    logic [COUNT_W-1:0] r_press_count;
    logic               r_overflow;
    logic [7:0]         r_mem [DEPTH];
    logic [AW:0]        r_wptr, r_rptr;
    logic               w_empty, w_full, w_push_req, w_push, w_pop;
    logic               w_mapped, w_letter;
    logic [7:0]         w_base, w_alt, w_char;

    assign w_shift = r_lshift | r_rshift;

    // Parser next state; only non-prefix bytes in IDLE/BRK are acted on
    always_comb begin
        w_state_next = r_state;
        w_make       = 1'b0;
        w_break      = 1'b0;
        if (bus.code_valid) begin
            unique case (r_state)
                StIdle: begin
                    if (bus.code_in == 8'hF0)      w_state_next = StBrk;
                    else if (bus.code_in == 8'hE0) w_state_next = StExt;
                    else                           w_make = 1'b1;
                end
                StBrk: begin
                    if (bus.code_in == 8'hE0) begin
                        w_state_next = StExtBrk;
                    end else if (bus.code_in != 8'hF0) begin
                        w_break      = 1'b1;
                        w_state_next = StIdle;
                    end
                end
                StExt: begin
                    if (bus.code_in == 8'hF0)      w_state_next = StExtBrk;
                    else if (bus.code_in != 8'hE0) w_state_next = StIdle;
                end
                StExtBrk: begin
                    if (bus.code_in != 8'hF0 && bus.code_in != 8'hE0) w_state_next = StIdle;
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    // Scan code to ASCII; letters flip case on shift^caps, digits use the shifted glyph in w_alt
    always_comb begin
        w_mapped = 1'b1;
        w_letter = 1'b0;
        w_base   = 8'h00;
        w_alt    = 8'h00;
        case (bus.code_in)
            8'h1C: begin w_base = 8'h61; w_letter = 1'b1; end
            8'h32: begin w_base = 8'h62; w_letter = 1'b1; end
            8'h21: begin w_base = 8'h63; w_letter = 1'b1; end
            8'h23: begin w_base = 8'h64; w_letter = 1'b1; end
            8'h24: begin w_base = 8'h65; w_letter = 1'b1; end
            8'h2B: begin w_base = 8'h66; w_letter = 1'b1; end
            8'h34: begin w_base = 8'h67; w_letter = 1'b1; end
            8'h33: begin w_base = 8'h68; w_letter = 1'b1; end
            8'h43: begin w_base = 8'h69; w_letter = 1'b1; end
            8'h3B: begin w_base = 8'h6A; w_letter = 1'b1; end
            8'h42: begin w_base = 8'h6B; w_letter = 1'b1; end
            8'h4B: begin w_base = 8'h6C; w_letter = 1'b1; end
            8'h3A: begin w_base = 8'h6D; w_letter = 1'b1; end
            8'h31: begin w_base = 8'h6E; w_letter = 1'b1; end
            8'h44: begin w_base = 8'h6F; w_letter = 1'b1; end
            8'h4D: begin w_base = 8'h70; w_letter = 1'b1; end
            8'h15: begin w_base = 8'h71; w_letter = 1'b1; end
            8'h2D: begin w_base = 8'h72; w_letter = 1'b1; end
            8'h1B: begin w_base = 8'h73; w_letter = 1'b1; end
            8'h2C: begin w_base = 8'h74; w_letter = 1'b1; end
            8'h3C: begin w_base = 8'h75; w_letter = 1'b1; end
            8'h2A: begin w_base = 8'h76; w_letter = 1'b1; end
            8'h1D: begin w_base = 8'h77; w_letter = 1'b1; end
            8'h22: begin w_base = 8'h78; w_letter = 1'b1; end
            8'h35: begin w_base = 8'h79; w_letter = 1'b1; end
            8'h1A: begin w_base = 8'h7A; w_letter = 1'b1; end
            8'h16: begin w_base = 8'h31; w_alt = 8'h21; end
            8'h1E: begin w_base = 8'h32; w_alt = 8'h40; end
            8'h26: begin w_base = 8'h33; w_alt = 8'h23; end
            8'h25: begin w_base = 8'h34; w_alt = 8'h24; end
            8'h2E: begin w_base = 8'h35; w_alt = 8'h25; end
            8'h36: begin w_base = 8'h36; w_alt = 8'h5E; end
            8'h3D: begin w_base = 8'h37; w_alt = 8'h26; end
            8'h3E: begin w_base = 8'h38; w_alt = 8'h2A; end
            8'h46: begin w_base = 8'h39; w_alt = 8'h28; end
            8'h45: begin w_base = 8'h30; w_alt = 8'h29; end
            8'h29: begin w_base = 8'h20; w_alt = 8'h20; end
            8'h5A: begin w_base = 8'h0D; w_alt = 8'h0D; end
            8'h66: begin w_base = 8'h08; w_alt = 8'h08; end
            default: w_mapped = 1'b0;
        endcase
        if (w_letter) w_char = (w_shift ^ w_caps) ? (w_base ^ 8'h20) : w_base;
        else          w_char = w_shift ? w_alt : w_base;
    end

`ifdef PS2DEC_CAPSLOCK_EN
    logic r_caps, r_caps_held;

    // Caps Lock toggles once per physical press; its own held bit masks typematic repeats
    always_ff @(posedge clk) begin
        if (rst) begin
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
        end else begin
            if (w_make && bus.code_in == 8'h58 && !r_caps_held) begin
                r_caps      <= ~r_caps;
                r_caps_held <= 1'b1;
            end
            if (w_break && bus.code_in == 8'h58) r_caps_held <= 1'b0;
        end
    end

    assign w_caps = r_caps;
`else
    assign w_caps = 1'b0;
`endif

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop      = !w_empty && bus.out_ready;
    assign w_push_req = w_make && w_mapped;
    // A slot freed by a same-cycle pop can take the new character
    assign w_push     = w_push_req && (!w_full || w_pop);

    // Parser state, modifiers, fresh-press tracking and FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_lshift      <= 1'b0;
            r_rshift      <= 1'b0;
            r_key_held    <= 1'b0;
            r_held_code   <= 8'h00;
            r_cur_ascii   <= 8'h00;
            r_press_count <= '0;
            r_overflow    <= 1'b0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_make && bus.code_in == 8'h12)  r_lshift <= 1'b1;
            if (w_make && bus.code_in == 8'h59)  r_rshift <= 1'b1;
            if (w_break && bus.code_in == 8'h12) r_lshift <= 1'b0;
            if (w_break && bus.code_in == 8'h59) r_rshift <= 1'b0;
            if (w_push_req && (!r_key_held || bus.code_in != r_held_code)) begin
                r_press_count <= r_press_count + COUNT_W'(1);
                r_cur_ascii   <= w_char;
                r_held_code   <= bus.code_in;
                r_key_held    <= 1'b1;
            end
            if (w_break && w_mapped && bus.code_in == r_held_code) r_key_held <= 1'b0;
            if (w_push) r_wptr <= r_wptr + (AW + 1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW + 1)'(1);
            if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    // FIFO storage, no reset needed since reads are gated by the empty flag
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= w_char;
    end

    assign bus.out_valid   = !w_empty;
    assign bus.out_data    = w_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];
    assign bus.cur_ascii   = r_cur_ascii;
    assign bus.key_held    = r_key_held;
    assign bus.press_count = r_press_count;
    assign bus.shift_on    = w_shift;
    assign bus.caps_on     = w_caps;
    assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: table-driven checks of the scan-code decoder plus directed sequences
// for typematic repeats, FIFO overflow, mid-sequence reset and (optionally) Caps Lock.
module tb_ps2_key_decoder;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ps2_key_decoder_if #(.COUNT_W(8)) bus ();

    ps2_key_decoder #(
        .DEPTH  (8),
        .COUNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       valid;
        logic [7:0] data;
        logic [7:0] cur;
        logic [7:0] cnt;
        logic       held;
        logic       shift;
    } vec_t;

    vec_t vecs [25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one byte for one cycle (code_valid stays high until idle), sample 1ns after edge
    task automatic send(input logic [7:0] code, input logic ready);
        @(negedge clk);
        bus.code_in    = code;
        bus.code_valid = 1'b1;
        bus.out_ready  = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.code_valid = 1'b0;
        bus.out_ready  = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        bus.code_valid = 1'b0;
        bus.out_ready  = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        bus.code_valid = 1'b0;
        bus.out_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] ovf_codes [10];
        logic [7:0] ovf_chars [8];
        n_checks       = 0;
        n_fail         = 0;
        clk            = 1'b0;
        rst            = 1'b1;
        bus.code_in    = 8'h00;
        bus.code_valid = 1'b0;
        bus.out_ready  = 1'b0;

        // code, valid, data, cur_ascii, press_count, key_held, shift_on
        vecs[0]  = '{8'h1C, 1'b1, 8'h61, 8'h61, 8'd1, 1'b1, 1'b0};
        vecs[1]  = '{8'hF0, 1'b0, 8'h00, 8'h61, 8'd1, 1'b1, 1'b0};
        vecs[2]  = '{8'h1C, 1'b0, 8'h00, 8'h61, 8'd1, 1'b0, 1'b0};
        vecs[3]  = '{8'h12, 1'b0, 8'h00, 8'h61, 8'd1, 1'b0, 1'b1};
        vecs[4]  = '{8'h1C, 1'b1, 8'h41, 8'h41, 8'd2, 1'b1, 1'b1};
        vecs[5]  = '{8'hF0, 1'b0, 8'h00, 8'h41, 8'd2, 1'b1, 1'b1};
        vecs[6]  = '{8'h1C, 1'b0, 8'h00, 8'h41, 8'd2, 1'b0, 1'b1};
        vecs[7]  = '{8'h16, 1'b1, 8'h21, 8'h21, 8'd3, 1'b1, 1'b1};
        vecs[8]  = '{8'hF0, 1'b0, 8'h00, 8'h21, 8'd3, 1'b1, 1'b1};
        vecs[9]  = '{8'h12, 1'b0, 8'h00, 8'h21, 8'd3, 1'b1, 1'b0};
        vecs[10] = '{8'h16, 1'b1, 8'h31, 8'h21, 8'd3, 1'b1, 1'b0};
        vecs[11] = '{8'hE0, 1'b0, 8'h00, 8'h21, 8'd3, 1'b1, 1'b0};
        vecs[12] = '{8'h75, 1'b0, 8'h00, 8'h21, 8'd3, 1'b1, 1'b0};
        vecs[13] = '{8'hE0, 1'b0, 8'h00, 8'h21, 8'd3, 1'b1, 1'b0};
        vecs[14] = '{8'hF0, 1'b0, 8'h00, 8'h21, 8'd3, 1'b1, 1'b0};
        vecs[15] = '{8'h75, 1'b0, 8'h00, 8'h21, 8'd3, 1'b1, 1'b0};
        vecs[16] = '{8'h32, 1'b1, 8'h62, 8'h62, 8'd4, 1'b1, 1'b0};
        vecs[17] = '{8'h76, 1'b0, 8'h00, 8'h62, 8'd4, 1'b1, 1'b0};
        vecs[18] = '{8'hF0, 1'b0, 8'h00, 8'h62, 8'd4, 1'b1, 1'b0};
        vecs[19] = '{8'h32, 1'b0, 8'h00, 8'h62, 8'd4, 1'b0, 1'b0};
        vecs[20] = '{8'h29, 1'b1, 8'h20, 8'h20, 8'd5, 1'b1, 1'b0};
        vecs[21] = '{8'h5A, 1'b1, 8'h0D, 8'h0D, 8'd6, 1'b1, 1'b0};
        vecs[22] = '{8'h66, 1'b1, 8'h08, 8'h08, 8'd7, 1'b1, 1'b0};
        vecs[23] = '{8'h45, 1'b1, 8'h30, 8'h30, 8'd8, 1'b1, 1'b0};
        vecs[24] = '{8'h4D, 1'b1, 8'h70, 8'h70, 8'd9, 1'b1, 1'b0};

        ovf_codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D};
        ovf_chars = '{8'h71, 8'h77, 8'h65, 8'h72, 8'h74, 8'h79, 8'h75, 8'h69};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_data", 32'(bus.out_data), 32'h00);
        check("rst cur_ascii", 32'(bus.cur_ascii), 32'h00);
        check("rst key_held", 32'(bus.key_held), 32'd0);
        check("rst press_count", 32'(bus.press_count), 32'd0);
        check("rst shift_on", 32'(bus.shift_on), 32'd0);
        check("rst caps_on", 32'(bus.caps_on), 32'd0);
        check("rst overflow", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table: back-to-back bytes with out_ready high; each pushed char pops next cycle
        for (int i = 0; i < 25; i++) begin
            send(vecs[i].code, 1'b1);
            check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].valid));
            if (vecs[i].valid)
                check($sformatf("vec%0d out_data", i), 32'(bus.out_data), 32'(vecs[i].data));
            check($sformatf("vec%0d cur_ascii", i), 32'(bus.cur_ascii), 32'(vecs[i].cur));
            check($sformatf("vec%0d press_count", i), 32'(bus.press_count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d key_held", i), 32'(bus.key_held), 32'(vecs[i].held));
            check($sformatf("vec%0d shift_on", i), 32'(bus.shift_on), 32'(vecs[i].shift));
        end
        idle();

        // Typematic repeats with consumer stalled: three entries, one press
        do_reset();
        for (int i = 0; i < 3; i++) send(8'h1C, 1'b0);
        idle();
        check("typematic press_count", 32'(bus.press_count), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("typematic valid%0d", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("typematic data%0d", i), 32'(bus.out_data), 32'h61);
            pop();
        end
        check("typematic drained", 32'(bus.out_valid), 32'd0);

        // Ten distinct makes into an 8-deep FIFO with consumer stalled
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(ovf_codes[i], 1'b0);
            if (i == 7) check("ovf before full", 32'(bus.overflow), 32'd0);
        end
        idle();
        check("ovf sticky", 32'(bus.overflow), 32'd1);
        check("ovf press_count", 32'(bus.press_count), 32'd10);
        check("ovf cur_ascii", 32'(bus.cur_ascii), 32'h70);
        check("ovf head stable", 32'(bus.out_data), 32'h71);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf valid%0d", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("ovf data%0d", i), 32'(bus.out_data), 32'(ovf_chars[i]));
            pop();
        end
        check("ovf drained", 32'(bus.out_valid), 32'd0);
        check("ovf still set", 32'(bus.overflow), 32'd1);

        // Reset right after F0: next byte is a make
        do_reset();
        send(8'hF0, 1'b0);
        @(negedge clk);
        rst            = 1'b1;
        bus.code_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(8'h1C, 1'b0);
        idle();
        check("midrst valid", 32'(bus.out_valid), 32'd1);
        check("midrst data", 32'(bus.out_data), 32'h61);
        check("midrst count", 32'(bus.press_count), 32'd1);
        check("midrst overflow", 32'(bus.overflow), 32'd0);

`ifdef PS2DEC_CAPSLOCK_EN
        do_reset();
        send(8'h58, 1'b1);
        check("caps toggle", 32'(bus.caps_on), 32'd1);
        check("caps no push", 32'(bus.out_valid), 32'd0);
        send(8'h58, 1'b1);
        check("caps held repeat", 32'(bus.caps_on), 32'd1);
        send(8'hF0, 1'b1);
        send(8'h58, 1'b1);
        check("caps release", 32'(bus.caps_on), 32'd1);
        send(8'h15, 1'b1);
        check("caps Q valid", 32'(bus.out_valid), 32'd1);
        check("caps Q data", 32'(bus.out_data), 32'h51);
        check("caps Q count", 32'(bus.press_count), 32'd1);
        send(8'h12, 1'b1);
        send(8'h15, 1'b1);
        check("caps shift q", 32'(bus.out_data), 32'h71);
        check("caps 1 digit", 32'(bus.caps_on), 32'd1);
        idle();
`else
        do_reset();
        send(8'h58, 1'b1);
        check("no caps flag", 32'(bus.caps_on), 32'd0);
        check("no caps push", 32'(bus.out_valid), 32'd0);
        check("no caps count", 32'(bus.press_count), 32'd0);
        idle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
